slc3_mem_arbiter: RTL and testbench

//  Memory-bus controller between the SLC-3 CPU (MAR/MDR path) and the board SRAM.
//  - Shares the SRAM between the CPU port and a debug/loader port.
//  - Sequences the SRAM strobes with a fixed wait count.
//  - Decodes one memory-mapped I/O word: read returns SW, write loads the HEX register.
//  - Returns a one-cycle ready (R) pulse that the CPU state controller waits on.

---
 rtl/slc3_mem_pkg.sv | 20 ++
 rtl/slc3_rr_arbiter.sv | 44 ++++
 rtl/slc3_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_slc3_mem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory-bus controller.
// Used by slc3_mem_arbiter and slc3_rr_arbiter.
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        IO
    } mem_state_t;

    typedef enum logic {
        GNT_CPU,
        GNT_DBG
    } grant_t;

    localparam logic [15:0] IO_ADDR_DEF = 16'hFFFF;
    localparam int SRAM_ADDR_W = 20;

endpackage

// File: rtl/slc3_rr_arbiter.sv
// Two-way round-robin arbiter: bit 0 = CPU, bit 1 = debug port.
// The pointer names the port preferred on the next contested grant.
module slc3_rr_arbiter
    import slc3_mem_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    grant_t ptr_q;
    grant_t ptr_d;

    always_comb begin
        grant = 2'b00;
        if (grant_en) begin
            if (req == 2'b11) begin
                grant = (ptr_q == GNT_CPU) ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        unique case (1'b1)
            grant[0]: ptr_d = GNT_DBG;
            grant[1]: ptr_d = GNT_CPU;
            default:  ptr_d = ptr_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ptr_q <= GNT_CPU;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/slc3_mem_arbiter.sv
// SLC-3 memory-bus controller: shares the SRAM between CPU and debug port, plus one I/O word.
// Define SLC3_DBG_PORT_EN to arbitrate the debug port; otherwise only the CPU is served.
module slc3_mem_arbiter
    import slc3_mem_pkg::*;
#(
    parameter int                ADDR_W  = 16,
    parameter int                DATA_W  = 16,
    parameter int                RD_WAIT = 2,
    parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_ADDR_DEF)
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_ready,
    input  logic                   dbg_req,
    input  logic                   dbg_we,
    input  logic [ADDR_W-1:0]      dbg_addr,
    input  logic [DATA_W-1:0]      dbg_wdata,
    output logic [DATA_W-1:0]      dbg_rdata,
    output logic                   dbg_ready,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_wdata,
    output logic                   sram_drive,
    input  logic [DATA_W-1:0]      sram_rdata,
    input  logic [9:0]             SW,
    output logic [15:0]            hex_out
);

    localparam int CNT_W = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;

    mem_state_t        state_q, state_d;
    grant_t            gnt_q, gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              drive_q, drive_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              dbg_ready_q, dbg_ready_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic [15:0]       hex_q, hex_d;

    logic              dbg_req_i;
    logic [1:0]        grant;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] io_word;

`ifdef SLC3_DBG_PORT_EN
    assign dbg_req_i = dbg_req;
    assign dbg_ready = dbg_ready_q;
    assign dbg_rdata = dbg_rdata_q;
`else
    logic unused_dbg;
    assign dbg_req_i  = 1'b0;
    assign dbg_ready  = 1'b0;
    assign dbg_rdata  = '0;
    assign unused_dbg = ^{dbg_req, dbg_ready_q, dbg_rdata_q};
`endif

    slc3_rr_arbiter u_rr (
        .Clk      (Clk),
        .Reset    (Reset),
        .req      ({dbg_req_i, cpu_req}),
        .grant_en (state_q == IDLE),
        .grant    (grant)
    );

    assign sel_we    = grant[1] ? dbg_we    : cpu_we;
    assign sel_addr  = grant[1] ? dbg_addr  : cpu_addr;
    assign sel_wdata = grant[1] ? dbg_wdata : cpu_wdata;
    assign io_word   = {{(DATA_W-10){1'b0}}, SW};

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        ce_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        we_n_d      = 1'b1;
        drive_d     = 1'b0;
        cpu_ready_d = 1'b0;
        dbg_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        hex_d       = hex_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    gnt_d   = grant[1] ? GNT_DBG : GNT_CPU;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (sel_addr == IO_ADDR) begin
                        state_d     = IO;
                        cpu_ready_d = grant[0];
                        dbg_ready_d = grant[1];
                        if (sel_we) begin
                            hex_d = 16'(sel_wdata);
                        end else if (grant[1]) begin
                            dbg_rdata_d = io_word;
                        end else begin
                            cpu_rdata_d = io_word;
                        end
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = CNT_W'(RD_WAIT - 1);
                        ce_n_d  = 1'b0;
                        oe_n_d  = sel_we;
                        we_n_d  = ~sel_we;
                        drive_d = sel_we;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Last strobed cycle: pads hold valid read data here
                    state_d     = DONE;
                    cpu_ready_d = (gnt_q == GNT_CPU);
                    dbg_ready_d = (gnt_q == GNT_DBG);
                    if (!we_q && gnt_q == GNT_CPU) cpu_rdata_d = sram_rdata;
                    if (!we_q && gnt_q == GNT_DBG) dbg_rdata_d = sram_rdata;
                end else begin
                    cnt_d   = cnt_q - 1'b1;
                    ce_n_d  = 1'b0;
                    oe_n_d  = we_q;
                    we_n_d  = ~we_q;
                    drive_d = we_q;
                end
            end
            DONE: state_d = IDLE;
            IO:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_CPU;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            drive_q     <= 1'b0;
            cpu_ready_q <= 1'b0;
            dbg_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            hex_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            drive_q     <= drive_d;
            cpu_ready_q <= cpu_ready_d;
            dbg_ready_q <= dbg_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            hex_q       <= hex_d;
        end
    end

    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_drive = drive_q;
    assign sram_addr  = SRAM_ADDR_W'(addr_q);
    assign sram_wdata = wdata_q;
    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign hex_out    = hex_q;

endmodule

// File: tb/tb_slc3_mem_arbiter.sv
// Directed self-checking bench for slc3_mem_arbiter with a small behavioural SRAM.
// Runs the round-robin test when SLC3_DBG_PORT_EN is defined, the debug-disabled test otherwise.
module tb_slc3_mem_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = '0, cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_ready;
    logic        dbg_req = 1'b0, dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0, dbg_wdata = '0;
    logic [15:0] dbg_rdata;
    logic        dbg_ready;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_drive;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic [9:0]  SW = '0;
    logic [15:0] hex_out;

    int checks = 0;
    int errors = 0;
    int tick_no = 0;
    int cpu_pulses = 0;
    int dbg_pulses = 0;
    int strobe_cnt = 0;
    int order[$];
    int ptime[$];

    logic [15:0] mem [256] = '{default: 16'h0000};

    slc3_mem_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_drive(sram_drive),
        .sram_rdata(sram_rdata), .SW(SW), .hex_out(hex_out)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        tick_no <= tick_no + 1;
        if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_wdata;
    end
    assign sram_rdata = mem[sram_addr[7:0]];

    always @(negedge Clk) begin
        if (cpu_ready) begin
            cpu_pulses <= cpu_pulses + 1;
            order.push_back(0);
            ptime.push_back(tick_no);
        end
        if (dbg_ready) begin
            dbg_pulses <= dbg_pulses + 1;
            order.push_back(1);
            ptime.push_back(tick_no);
        end
        if (!sram_ce_n || !sram_oe_n || !sram_we_n) strobe_cnt <= strobe_cnt + 1;
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic cpu_access(input logic we, input logic [15:0] a,
                              input logic [15:0] d, output int lat,
                              output logic [15:0] rd);
        cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
        lat = 0;
        rd = '0;
        for (int i = 0; i < 20; i++) begin
            tick;
            lat++;
            if (cpu_ready) break;
        end
        checks++;
        if (cpu_ready !== 1'b1) begin
            errors++;
            $display("FAIL cpu_access_timeout: addr %h ready %b required 1", a, cpu_ready);
        end
        rd = cpu_rdata;
        cpu_req = 1'b0;
        tick;
    endtask

    task automatic test_reset;
        #23;
        checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_drive} !== 4'b1110) begin errors++; $display("FAIL reset_strobes: got %b required 1110", {sram_ce_n, sram_oe_n, sram_we_n, sram_drive}); end
        checks++; if (sram_addr !== 20'h0) begin errors++; $display("FAIL reset_addr: got %h required 00000", sram_addr); end
        checks++; if ({cpu_ready, dbg_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b required 00", {cpu_ready, dbg_ready}); end
        checks++; if ({cpu_rdata, dbg_rdata, hex_out} !== 48'h0) begin errors++; $display("FAIL reset_regs: got %h required 0", {cpu_rdata, dbg_rdata, hex_out}); end
        Reset = 1'b1;
        tick;
        checks++; if (sram_ce_n !== 1'b1) begin errors++; $display("FAIL reset_idle: ce_n %b required 1", sram_ce_n); end
    endtask

    task automatic test_abort;
        int base;
        base = cpu_pulses;
        cpu_we = 1'b1; cpu_addr = 16'h3010; cpu_wdata = 16'h5555; cpu_req = 1'b1;
        tick;
        checks++; if ({sram_ce_n, sram_drive} !== 2'b01) begin errors++; $display("FAIL abort_in_access: ce_n/drive %b required 01", {sram_ce_n, sram_drive}); end
        #2 Reset = 1'b0;
        #1;
        checks++; if ({sram_ce_n, sram_we_n, sram_drive} !== 3'b110) begin errors++; $display("FAIL abort_strobes: got %b required 110", {sram_ce_n, sram_we_n, sram_drive}); end
        cpu_req = 1'b0;
        #2 Reset = 1'b1;
        repeat (6) tick;
        checks++; if (cpu_pulses - base !== 0) begin errors++; $display("FAIL abort_no_ready: pulses %0d required 0", cpu_pulses - base); end
        checks++; if (hex_out !== 16'h0) begin errors++; $display("FAIL abort_hex: got %h required 0000", hex_out); end
    endtask

    task automatic test_sram_rw;
        int lat;
        logic [15:0] rd;
        cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 16'hBEEF; cpu_req = 1'b1;
        tick;
        checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_drive, cpu_ready} !== 5'b01010) begin errors++; $display("FAIL wr_access1: got %b required 01010", {sram_ce_n, sram_oe_n, sram_we_n, sram_drive, cpu_ready}); end
        checks++; if ({sram_addr, sram_wdata} !== 36'h03000BEEF) begin errors++; $display("FAIL wr_bus: got %h required 03000beef", {sram_addr, sram_wdata}); end
        tick;
        checks++; if ({sram_ce_n, sram_we_n, sram_drive, cpu_ready} !== 4'b0010) begin errors++; $display("FAIL wr_access2: got %b required 0010", {sram_ce_n, sram_we_n, sram_drive, cpu_ready}); end
        tick;
        checks++; if ({sram_ce_n, sram_we_n, sram_drive, cpu_ready} !== 4'b1101) begin errors++; $display("FAIL wr_done: got %b required 1101", {sram_ce_n, sram_we_n, sram_drive, cpu_ready}); end
        cpu_req = 1'b0;
        tick;
        cpu_access(1'b0, 16'h3000, 16'h0, lat, rd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d required 3", lat); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL rd_data: got %h required beef", rd); end
    endtask

    task automatic test_io;
        int lat, s0;
        logic [15:0] rd;
        SW = 10'h00E;
        s0 = strobe_cnt;
        cpu_access(1'b0, 16'hFFFF, 16'h0, lat, rd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL io_rd_latency: got %0d required 1", lat); end
        checks++; if (rd !== 16'h000E) begin errors++; $display("FAIL io_rd_data: got %h required 000e", rd); end
        cpu_access(1'b1, 16'hFFFF, 16'h1234, lat, rd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL io_wr_latency: got %0d required 1", lat); end
        checks++; if (hex_out !== 16'h1234) begin errors++; $display("FAIL io_hex: got %h required 1234", hex_out); end
        checks++; if (cpu_rdata !== 16'h000E) begin errors++; $display("FAIL io_wr_keeps_rdata: got %h required 000e", cpu_rdata); end
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL io_no_strobes: got %0d strobe cycles required 0", strobe_cnt - s0); end
    endtask

    task automatic test_drop_req;
        int base;
        base = cpu_pulses;
        cpu_we = 1'b0; cpu_addr = 16'h3000; cpu_req = 1'b1;
        tick;
        cpu_req = 1'b0;
        repeat (8) tick;
        checks++; if (cpu_pulses - base !== 1) begin errors++; $display("FAIL drop_ready_count: got %0d required 1", cpu_pulses - base); end
        checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("FAIL drop_rdata: got %h required beef", cpu_rdata); end
    endtask

`ifdef SLC3_DBG_PORT_EN
    task automatic test_round_robin;
        int lat, b, bi;
        int exp_who[4] = '{0, 1, 0, 1};
        logic [15:0] rd;
        cpu_access(1'b1, 16'h3040, 16'hAAAA, lat, rd);
        cpu_access(1'b1, 16'h3050, 16'h5555, lat, rd);
        Reset = 1'b0;
        #3 Reset = 1'b1;
        tick;
        cpu_we = 1'b0; cpu_addr = 16'h3040; cpu_req = 1'b1;
        dbg_we = 1'b0; dbg_addr = 16'h3050; dbg_req = 1'b1;
        b = tick_no;
        bi = order.size();
        repeat (16) tick;
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (6) tick;
        checks++; if (order.size() - bi !== 4) begin errors++; $display("FAIL rr_grant_count: got %0d required 4", order.size() - bi); end
        for (int k = 0; k < 4; k++) begin
            if (bi + k < order.size()) begin
                checks++; if (order[bi+k] !== exp_who[k]) begin errors++; $display("FAIL rr_order[%0d]: got %0d required %0d (0=cpu 1=dbg)", k, order[bi+k], exp_who[k]); end
                checks++; if (ptime[bi+k] !== b + 3 + 4 * k) begin errors++; $display("FAIL rr_time[%0d]: got %0d required %0d", k, ptime[bi+k] - b, 3 + 4 * k); end
            end
        end
        checks++; if (cpu_rdata !== 16'hAAAA) begin errors++; $display("FAIL rr_cpu_rdata: got %h required aaaa", cpu_rdata); end
        checks++; if (dbg_rdata !== 16'h5555) begin errors++; $display("FAIL rr_dbg_rdata: got %h required 5555", dbg_rdata); end
    endtask
`else
    task automatic test_no_dbg;
        int lat, s0, d0;
        logic [15:0] rd;
        d0 = dbg_pulses;
        s0 = strobe_cnt;
        dbg_we = 1'b0; dbg_addr = 16'h3000; dbg_req = 1'b1;
        repeat (4) tick;
        checks++; if (strobe_cnt - s0 !== 0) begin errors++; $display("FAIL nodbg_idle: got %0d strobe cycles required 0", strobe_cnt - s0); end
        cpu_access(1'b0, 16'h3000, 16'h0, lat, rd);
        checks++; if (lat !== 3) begin errors++; $display("FAIL nodbg_cpu_latency: got %0d required 3", lat); end
        checks++; if (rd !== 16'hBEEF) begin errors++; $display("FAIL nodbg_cpu_rdata: got %h required beef", rd); end
        checks++; if (dbg_pulses - d0 !== 0) begin errors++; $display("FAIL nodbg_ready: got %0d pulses required 0", dbg_pulses - d0); end
        checks++; if (dbg_rdata !== 16'h0) begin errors++; $display("FAIL nodbg_rdata: got %h required 0000", dbg_rdata); end
        dbg_req = 1'b0;
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_abort;
        test_sram_rw;
        test_io;
        test_drop_req;
`ifdef SLC3_DBG_PORT_EN
        test_round_robin;
`else
        test_no_dbg;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
